cpu_trace_monitor: RTL and testbench

Synthesizable data-memory write tracer and run-control block that sits beside the CPU on the data-memory write bus and the instruction-address bus. It timestamps qualifying stores into a show-ahead FIFO for later readout by a host or debug port. It halts itself when the program counter reaches a configured stop address. Width, depth, address filter window and stop address are all configurable, so the block serves both simulation and on-FPGA bring-up.

---
 rtl/cpu_trace_monitor.sv | 156 +++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: data-memory store tracer with run control.
// Stores that hit the address window while in RUN are timestamped into a
// show-ahead FIFO. The block halts itself when the PC reaches STOP_ADDR.
// Ports:
//   CLK, RST                 clock, async active-high reset
//   enable_i, clear_i        arm tracing / synchronous flush and restart
//   inst_mem_address_i       CPU program counter
//   data_mem_*_i             store address, data and write strobe
//   win_lo_i, win_hi_i       inclusive capture window
//   rd_en_i, rd_*_o          FIFO pop and head entry
//   count_o, overflow_o, dropped_o   occupancy and drop statistics
//   cycle_o, halted_o        run-cycle counter and halted flag
module cpu_trace_monitor #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CYC_W  = 32,
  parameter logic [ADDR_W-1:0] STOP_ADDR = ADDR_W'(187)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enable_i,
  input  logic                       clear_i,
  input  logic [ADDR_W-1:0]          inst_mem_address_i,
  input  logic [ADDR_W-1:0]          data_mem_address_i,
  input  logic [DATA_W-1:0]          data_mem_in_data_i,
  input  logic                       data_mem_WE_i,
  input  logic [ADDR_W-1:0]          win_lo_i,
  input  logic [ADDR_W-1:0]          win_hi_i,
  input  logic                       rd_en_i,
  output logic                       rd_valid_o,
  output logic [ADDR_W-1:0]          rd_addr_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [CYC_W-1:0]           rd_cycle_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [15:0]                dropped_o,
  output logic [CYC_W-1:0]           cycle_o,
  output logic                       halted_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W + CYC_W;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cycle_q, cycle_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         dropped_q, dropped_d;
  logic [EntW-1:0]     mem_q [DEPTH];
  logic [EntW-1:0]     last_q, last_d;

  logic                in_window, push_req, full, empty, pop, push, drop;
  logic [EntW-1:0]     new_ent, head_ent, out_ent;

  // An inverted window (lo > hi) can never satisfy both bounds.
  assign in_window = (data_mem_address_i >= win_lo_i) && (data_mem_address_i <= win_hi_i);
  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push_req  = (state_q == StRun) && data_mem_WE_i && in_window && !clear_i;
  assign pop       = rd_en_i && !empty && !clear_i;
  // Full FIFO still accepts a push when the head is leaving on the same edge.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign new_ent   = {data_mem_address_i, data_mem_in_data_i, cycle_q};
  assign head_ent  = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable_i) state_d = StRun;
      StRun: begin
        // Halt wins over a simultaneous enable drop.
        if (inst_mem_address_i == STOP_ADDR) state_d = StHalted;
        else if (!enable_i)                  state_d = StIdle;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
    if (clear_i) state_d = StIdle;
  end

  always_comb begin
    cycle_d    = cycle_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    dropped_d  = dropped_q;
    last_d     = last_q;
    if (clear_i) begin
      cycle_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      dropped_d  = '0;
    end else begin
      if (state_q == StRun) cycle_d = cycle_q + CYC_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        // Remember the popped entry so outputs hold it once empty.
        last_d   = head_ent;
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (drop) begin
        overflow_d = 1'b1;
        if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      cycle_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
      last_q     <= last_d;
    end
  end

  // Storage needs no reset: count_q masks stale slots.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= new_ent;
  end

  assign out_ent    = empty ? last_q : head_ent;
  assign rd_valid_o = !empty;
  assign rd_addr_o  = out_ent[EntW-1 -: ADDR_W];
  assign rd_data_o  = out_ent[CYC_W +: DATA_W];
  assign rd_cycle_o = out_ent[CYC_W-1:0];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign dropped_o  = dropped_q;
  assign cycle_o    = cycle_q;
  assign halted_o   = (state_q == StHalted);

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Scoreboard bench for cpu_trace_monitor: expected entries are queued when a
// capturing store is issued; a negedge monitor checks each popped head entry.
module tb_cpu_trace_monitor;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] c;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enable_i = 1'b0, clear_i = 1'b0, we = 1'b0, rd_en = 1'b0;
  logic [31:0] pc = '0, addr = '0, data = '0, win_lo = '0, win_hi = 32'd1023;
  logic        rd_valid, overflow, halted;
  logic [31:0] rd_addr, rd_data, rd_cycle, cycle;
  logic [4:0]  count;
  logic [15:0] dropped;

  ent_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mrun = 1'b0;
  logic [31:0] mcyc = '0;

  cpu_trace_monitor dut (
    .CLK(CLK), .RST(RST), .enable_i(enable_i), .clear_i(clear_i),
    .inst_mem_address_i(pc), .data_mem_address_i(addr), .data_mem_in_data_i(data),
    .data_mem_WE_i(we), .win_lo_i(win_lo), .win_hi_i(win_hi), .rd_en_i(rd_en),
    .rd_valid_o(rd_valid), .rd_addr_o(rd_addr), .rd_data_o(rd_data), .rd_cycle_o(rd_cycle),
    .count_o(count), .overflow_o(overflow), .dropped_o(dropped), .cycle_o(cycle),
    .halted_o(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT will take is checked against the queue head.
  always @(negedge CLK) begin
    if (!RST && rd_en && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pop_unexpected: got addr %0h expected no entry", rd_addr);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("head_addr", rd_addr, e.a);
        chk("head_data", rd_data, e.d);
        chk("head_cycle", rd_cycle, e.c);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    if (mrun) mcyc++;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit cap);
    addr = a;
    data = d;
    we   = 1'b1;
    if (cap) exp_q.push_back({a, d, mcyc});
    step();
    we = 1'b0;
  endtask

  task automatic do_clear();
    enable_i = 1'b0;
    clear_i  = 1'b1;
    step();
    clear_i  = 1'b0;
    mrun     = 1'b0;
    mcyc     = '0;
  endtask

  task automatic do_enable();
    enable_i = 1'b1;
    step();
    mrun = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_cycle", cycle, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_dropped", 32'(dropped), 0);
    #10 RST = 1'b0;
    step();

    // Basic capture: stores stamped at cycles 3 and 5
    do_enable();
    step(); step(); step();
    store(32'd4, 32'd10, 1'b1);
    step();
    store(32'd8, 32'd20, 1'b1);
    chk("basic_count2", 32'(count), 2);
    chk("basic_cycle", cycle, mcyc);
    rd_en = 1'b1;
    step();
    chk("basic_count1", 32'(count), 1);
    step();
    rd_en = 1'b0;
    chk("basic_count0", 32'(count), 0);
    chk("basic_valid0", 32'(rd_valid), 0);

    // Address filter
    do_clear();
    win_lo = 32'd100;
    win_hi = 32'd200;
    do_enable();
    store(32'd99,  32'h1, 1'b0);
    store(32'd100, 32'h2, 1'b1);
    store(32'd200, 32'h3, 1'b1);
    store(32'd201, 32'h4, 1'b0);
    chk("filt_count", 32'(count), 2);
    rd_en = 1'b1;
    step(); step();
    rd_en = 1'b0;
    win_lo = 32'd300;
    store(32'd250, 32'h5, 1'b0);
    store(32'd300, 32'h6, 1'b0);
    store(32'd200, 32'h7, 1'b0);
    chk("inv_window_count", 32'(count), 0);

    // Overflow: 20 stores into 16 entries
    do_clear();
    win_lo = 32'd0;
    win_hi = 32'd1023;
    do_enable();
    for (int i = 0; i < 20; i++) store(32'(i * 4), 32'(i + 100), i < 16);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_dropped", 32'(dropped), 4);
    chk("ovf_head", rd_addr, 0);
    rd_en = 1'b1;
    store(32'd400, 32'd500, 1'b1);
    rd_en = 1'b0;
    chk("full_pushpop_count", 32'(count), 16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rd_en = 1'b0;
    chk("ovf_drained", 32'(count), 0);

    // Halt on STOP_ADDR; clear zeroes sticky state left by overflow
    do_clear();
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_dropped", 32'(dropped), 0);
    do_enable();
    store(32'h10, 32'd1, 1'b1);
    pc = 32'd187;
    store(32'h14, 32'd2, 1'b1);
    pc = 32'd0;
    mrun = 1'b0;
    chk("halt_flag", 32'(halted), 1);
    chk("halt_cycle", cycle, mcyc);
    for (int i = 0; i < 3; i++) store(32'h20 + 32'(i), 32'd9, 1'b0);
    chk("halt_frozen", cycle, mcyc);
    chk("halt_count", 32'(count), 2);
    rd_en = 1'b1;
    step(); step();
    rd_en = 1'b0;
    chk("halt_drained", 32'(count), 0);
    chk("halt_still", 32'(halted), 1);
    do_clear();
    chk("clr_halted", 32'(halted), 0);
    chk("clr_cycle", cycle, 0);

    // Async reset with 5 entries queued
    do_enable();
    for (int i = 0; i < 5; i++) store(32'(i), 32'(i), 1'b0);
    chk("pre_rst_count", 32'(count), 5);
    #2 RST = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_cycle", cycle, 0);
    chk("arst_halted", 32'(halted), 0);
    enable_i = 1'b0;
    mrun = 1'b0;
    mcyc = '0;
    @(negedge CLK);
    RST = 1'b0;
    step();

    // Pointer wrap at occupancy 1
    do_enable();
    rd_en = 1'b1;
    for (int i = 0; i < 48; i++) store(32'(i * 8), 32'hA000 + 32'(i), 1'b1);
    step();
    rd_en = 1'b0;
    chk("wrap_overflow", 32'(overflow), 0);
    chk("wrap_count", 32'(count), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
